button_reader: RTL and testbench



---
 rtl/button_reader_pkg.sv | 19 +
 rtl/button_channel.sv | 141 ++++++++++++++
 rtl/button_reader.sv | 39 +++
 tb/tb_button_reader.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/button_reader_pkg.sv
// Shared types and default timing for the button reader.
// The defaults assume the 3.3 MHz oscillator domain.
package button_reader_pkg;

   typedef enum logic [1:0] {
      StReleased = 2'd0,
      StPressed  = 2'd1,
      StHeld     = 2'd2
   } btn_state_e;

   // 5 ms debounce and 1 s long press at 3.3 MHz
   localparam int unsigned DEFAULT_DEBOUNCE_CYCLES   = 16500;
   localparam int unsigned DEFAULT_LONG_PRESS_CYCLES = 3300000;

   function automatic int unsigned cnt_width(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/button_channel.sv
// One button channel: 2-flop synchroniser, debounce, press/held FSM and toggle.
// IDLE_LEVEL is the raw pin level when the button is not pressed.
module button_channel
   import button_reader_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
   parameter int unsigned LONG_PRESS_CYCLES = DEFAULT_LONG_PRESS_CYCLES,
   parameter bit          IDLE_LEVEL        = 1'b1
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic btn_i,
   output logic level_o,
   output logic press_o,
   output logic release_o,
   output logic long_o,
   output logic toggle_o
);

   localparam int unsigned DB_W   = cnt_width(DEBOUNCE_CYCLES);
   localparam int unsigned HOLD_W = cnt_width(LONG_PRESS_CYCLES);

   localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);
   // Firing one count early lets the pulse land in the cycle the count hits HOLD_LAST
   localparam logic [HOLD_W-1:0] HOLD_FIRE = HOLD_W'(LONG_PRESS_CYCLES - 2);

   logic [1:0]        sync_q;
   logic              pressed;
   logic              level_q, level_d;
   logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
   logic              differ, flip;

   btn_state_e        state_q, state_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic              toggle_q, toggle_d;
   logic              press_q, press_d;
   logic              release_q, release_d;
   logic              long_q, long_d;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q <= {2{IDLE_LEVEL}};
      end else begin
         sync_q <= {sync_q[0], btn_i};
      end
   end

   assign pressed = sync_q[1] ^ IDLE_LEVEL;
   assign differ  = (pressed != level_q);
   assign flip    = differ && (db_cnt_q == DB_LAST);

   always_comb begin
      db_cnt_d = '0;
      level_d  = level_q;
      if (differ) begin
         if (db_cnt_q == DB_LAST) begin
            level_d = ~level_q;
         end else begin
            db_cnt_d = db_cnt_q + DB_W'(1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         level_q  <= 1'b0;
         db_cnt_q <= '0;
      end else begin
         level_q  <= level_d;
         db_cnt_q <= db_cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      hold_d    = hold_q;
      toggle_d  = toggle_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      long_d    = 1'b0;
      unique case (state_q)
         StReleased: begin
            if (flip && !level_q) begin
               state_d  = StPressed;
               press_d  = 1'b1;
               toggle_d = ~toggle_q;
               hold_d   = '0;
            end
         end
         StPressed: begin
            if (flip && level_q) begin
               state_d   = StReleased;
               release_d = 1'b1;
            end else begin
               if (hold_q != HOLD_LAST) begin
                  hold_d = hold_q + HOLD_W'(1);
               end
               if (hold_q == HOLD_FIRE) begin
                  state_d = StHeld;
                  long_d  = 1'b1;
               end
            end
         end
         StHeld: begin
            if (flip && level_q) begin
               state_d   = StReleased;
               release_d = 1'b1;
            end
         end
         default: begin
            state_d = StReleased;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= StReleased;
         hold_q    <= '0;
         toggle_q  <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
         long_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         hold_q    <= hold_d;
         toggle_q  <= toggle_d;
         press_q   <= press_d;
         release_q <= release_d;
         long_q    <= long_d;
      end
   end

   assign level_o   = level_q;
   assign press_o   = press_q;
   assign release_o = release_q;
   assign long_o    = long_q;
   assign toggle_o  = toggle_q;

endmodule

// File: rtl/button_reader.sv
// Debounced multi-button reader: clean levels, press/release/long-press pulses
// and a per-button toggle, one independent channel per pin.
module button_reader
   import button_reader_pkg::*;
#(
   parameter int unsigned NUM_BTN           = 4,
   parameter int unsigned DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
   parameter int unsigned LONG_PRESS_CYCLES = DEFAULT_LONG_PRESS_CYCLES,
   parameter bit          ACTIVE_LOW        = 1'b1
) (
   input  logic               CLK,
   input  logic               RST_N,
   input  logic [NUM_BTN-1:0] BTN_IN,
   output logic [NUM_BTN-1:0] BTN_LEVEL,
   output logic [NUM_BTN-1:0] PRESS_PULSE,
   output logic [NUM_BTN-1:0] RELEASE_PULSE,
   output logic [NUM_BTN-1:0] LONG_PULSE,
   output logic [NUM_BTN-1:0] TOGGLE
);

   // Released pin level is 1 for active-low buttons; the channel normalises from it
   for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
      button_channel #(
         .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
         .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES),
         .IDLE_LEVEL       (ACTIVE_LOW)
      ) u_chan (
         .clk_i    (CLK),
         .rst_ni   (RST_N),
         .btn_i    (BTN_IN[i]),
         .level_o  (BTN_LEVEL[i]),
         .press_o  (PRESS_PULSE[i]),
         .release_o(RELEASE_PULSE[i]),
         .long_o   (LONG_PULSE[i]),
         .toggle_o (TOGGLE[i])
      );
   end

endmodule

// File: tb/tb_button_reader.sv
// Bench for button_reader: directed scenarios plus random pin activity, all
// checked every cycle against a behavioural stability/age model.
module tb_button_reader;

   localparam int unsigned NB = 4;
   localparam int unsigned DB = 8;
   localparam int unsigned LP = 32;
   localparam bit ACTIVE_LOW  = 1'b1;

   logic          CLK = 1'b0;
   logic          RST_N = 1'b0;
   logic [NB-1:0] BTN_IN = 4'hF;
   logic [NB-1:0] BTN_LEVEL, PRESS_PULSE, RELEASE_PULSE, LONG_PULSE, TOGGLE;

   button_reader #(
      .NUM_BTN          (NB),
      .DEBOUNCE_CYCLES  (DB),
      .LONG_PRESS_CYCLES(LP),
      .ACTIVE_LOW       (ACTIVE_LOW)
   ) dut (
      .CLK          (CLK),
      .RST_N        (RST_N),
      .BTN_IN       (BTN_IN),
      .BTN_LEVEL    (BTN_LEVEL),
      .PRESS_PULSE  (PRESS_PULSE),
      .RELEASE_PULSE(RELEASE_PULSE),
      .LONG_PULSE   (LONG_PULSE),
      .TOGGLE       (TOGGLE)
   );

   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference model: a level is accepted once the synchronised pin has
   // disagreed with it for DB consecutive cycles; long press fires LP-1
   // cycles after the press pulse, once per press.
   logic [NB-1:0] h1, h2;
   logic [NB-1:0] m_lvl, m_press, m_rel, m_long, m_tog, m_ldone;
   int            m_run [NB];
   int            m_age [NB];
   int            cnt_press [NB];
   int            cnt_rel [NB];
   int            cnt_long [NB];

   task automatic model_reset();
      h1 = '0; h2 = '0;
      m_lvl = '0; m_press = '0; m_rel = '0; m_long = '0; m_tog = '0; m_ldone = '0;
      for (int c = 0; c < NB; c++) begin
         m_run[c] = 0;
         m_age[c] = 0;
      end
   endtask

   task automatic model_step();
      m_press = '0; m_rel = '0; m_long = '0;
      for (int c = 0; c < NB; c++) begin
         if (h2[c] != m_lvl[c]) begin
            m_run[c]++;
            if (m_run[c] == DB) begin
               m_run[c] = 0;
               m_lvl[c] = ~m_lvl[c];
               if (m_lvl[c]) begin
                  m_press[c] = 1'b1;
                  m_tog[c]   = ~m_tog[c];
                  m_age[c]   = 0;
                  m_ldone[c] = 1'b0;
               end else begin
                  m_rel[c] = 1'b1;
               end
               continue;
            end
         end else begin
            m_run[c] = 0;
         end
         if (m_lvl[c] && !m_ldone[c]) begin
            m_age[c]++;
            if (m_age[c] == LP - 1) begin
               m_long[c]  = 1'b1;
               m_ldone[c] = 1'b1;
            end
         end
      end
      h2 = h1;
      h1 = ACTIVE_LOW ? ~BTN_IN : BTN_IN;
   endtask

   task automatic tick();
      @(posedge CLK);
      if (RST_N) model_step();
      @(negedge CLK);
      check_eq("level",   32'(BTN_LEVEL),     32'(m_lvl));
      check_eq("press",   32'(PRESS_PULSE),   32'(m_press));
      check_eq("release", 32'(RELEASE_PULSE), 32'(m_rel));
      check_eq("long",    32'(LONG_PULSE),    32'(m_long));
      check_eq("toggle",  32'(TOGGLE),        32'(m_tog));
      for (int c = 0; c < NB; c++) begin
         if (PRESS_PULSE[c])   cnt_press[c]++;
         if (RELEASE_PULSE[c]) cnt_rel[c]++;
         if (LONG_PULSE[c])    cnt_long[c]++;
      end
   endtask

   // which: 0 press, 1 release, 2 long. t = ticks until seen, -1 if never.
   task automatic wait_bit(input int which, input int ch, input int limit, output int t);
      logic hit;
      t = -1;
      for (int i = 1; i <= limit; i++) begin
         tick();
         case (which)
            0:       hit = PRESS_PULSE[ch];
            1:       hit = RELEASE_PULSE[ch];
            default: hit = LONG_PULSE[ch];
         endcase
         if (hit) begin
            t = i;
            break;
         end
      end
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_level"},   32'(BTN_LEVEL),     32'd0);
      check_eq({tag, "_press"},   32'(PRESS_PULSE),   32'd0);
      check_eq({tag, "_release"}, 32'(RELEASE_PULSE), 32'd0);
      check_eq({tag, "_long"},    32'(LONG_PULSE),    32'd0);
      check_eq({tag, "_toggle"},  32'(TOGGLE),        32'd0);
   endtask

   initial begin
      int t, t2, rate;
      for (int c = 0; c < NB; c++) begin
         cnt_press[c] = 0; cnt_rel[c] = 0; cnt_long[c] = 0;
      end
      model_reset();

      // Reset with all buttons released, then 100 quiet cycles
      #1;
      check_all_zero("reset");
      @(negedge CLK);
      @(negedge CLK);
      RST_N = 1'b1;
      ticks(100);
      check_eq("quiet_press", 32'(cnt_press[0] + cnt_press[1] + cnt_press[2] + cnt_press[3]), 32'd0);

      // Clean press on channel 0
      BTN_IN[0] = 1'b0;
      wait_bit(0, 0, 20, t);
      check_eq("press0_latency", 32'(t), 32'd10);
      check_eq("press0_level", 32'(BTN_LEVEL[0]), 32'd1);
      check_eq("press0_toggle", 32'(TOGGLE[0]), 32'd1);
      check_eq("press0_others", 32'(PRESS_PULSE[3:1]), 32'd0);
      ticks(10);
      BTN_IN[0] = 1'b1;
      ticks(20);

      // Short glitch on channel 1 is rejected
      BTN_IN[1] = 1'b0;
      ticks(5);
      BTN_IN[1] = 1'b1;
      ticks(30);
      check_eq("glitch1_press", 32'(cnt_press[1]), 32'd0);
      check_eq("glitch1_level", 32'(BTN_LEVEL[1]), 32'd0);

      // Long press on channel 2
      BTN_IN[2] = 1'b0;
      wait_bit(0, 2, 20, t);
      check_eq("long2_press_at", 32'(t), 32'd10);
      wait_bit(2, 2, 40, t2);
      check_eq("long2_long_at", 32'(t + t2), 32'd41);
      ticks(19);
      check_eq("long2_single", 32'(cnt_long[2]), 32'd1);
      BTN_IN[2] = 1'b1;
      wait_bit(1, 2, 20, t);
      check_eq("long2_release_at", 32'(t), 32'd10);
      ticks(10);

      // Four press/release cycles on channel 3
      for (int k = 0; k < 4; k++) begin
         BTN_IN[3] = 1'b0;
         wait_bit(0, 3, 20, t);
         check_eq("seq3_press_at", 32'(t), 32'd10);
         check_eq("seq3_toggle", 32'(TOGGLE[3]), 32'((k % 2 == 0) ? 1 : 0));
         ticks(5);
         BTN_IN[3] = 1'b1;
         wait_bit(1, 3, 20, t);
         check_eq("seq3_release_at", 32'(t), 32'd10);
         check_eq("seq3_presses", 32'(cnt_press[3]), 32'(k + 1));
         check_eq("seq3_pairing", 32'(cnt_press[3] - cnt_rel[3]), 32'd0);
         ticks(3);
      end

      // Async reset while channel 0 is held past its long press
      BTN_IN[0] = 1'b0;
      t = cnt_long[0];
      ticks(45);
      check_eq("rst0_long_seen", 32'(cnt_long[0] - t), 32'd1);
      RST_N = 1'b0;
      #1;
      check_all_zero("midrst");
      model_reset();
      @(negedge CLK);
      RST_N = 1'b1;
      wait_bit(0, 0, 20, t);
      check_eq("rst0_repress_at", 32'(t), 32'd10);
      check_eq("rst0_toggle", 32'(TOGGLE[0]), 32'd1);
      BTN_IN[0] = 1'b1;
      ticks(20);

      // Random pin activity with varying flip rates and one async reset
      for (int cyc = 0; cyc < 3000; cyc++) begin
         case ((cyc / 500) % 3)
            0:       rate = 4;
            1:       rate = 12;
            default: rate = 60;
         endcase
         for (int c = 0; c < NB; c++) begin
            if ($urandom_range(rate - 1, 0) == 0) BTN_IN[c] = ~BTN_IN[c];
         end
         if (cyc == 1700) begin
            RST_N = 1'b0;
            #1;
            check_all_zero("rand_rst");
            model_reset();
            @(negedge CLK);
            @(negedge CLK);
            RST_N = 1'b1;
         end
         tick();
      end

      BTN_IN = 4'hF;
      ticks(60);
      check_eq("final_level", 32'(BTN_LEVEL), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
